// File: rtl/ysyx_25040129_lsu.sv
// ysyx_25040129_lsu -- load/store unit between execute and writeback.
//
// Accepts one operation at a time from the execute stage. Memory operations
// issue a single aligned 32-bit bus request and wait for its response. All
// other operations pass the ALU result straight to writeback.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         request from execute
//   in_result                 effective address, or writeback value for non-memory ops
//   in_wdata                  store data
//   in_read                   load kind: 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, others none
//   in_write                  store kind: 1 SB, 2 SH, 3 SW, 0 none
//   in_rd, in_reg_write       destination register and its write enable
//   mem_req_valid/ready       bus request handshake
//   mem_addr/wen/wdata/wstrb  bus request payload
//   mem_rsp_valid/rdata/err   bus response, always accepted
//   wb_valid/wb_ready         writeback handshake
//   wb_data/rd/reg_write      writeback payload
//   lsu_fault                 bus error or misaligned access
//
// Build option
//   YSYX_25040129_LSU_MISALIGN_CHK_EN: misaligned half/word accesses skip the
//   bus and are reported as faults. When undefined, no alignment check is made.
//
// state | meaning
// IDLE  | ready for a new operation
// REQ   | bus request presented, waiting for mem_req_ready
// RESP  | waiting for the bus response
// DONE  | writeback presented, waiting for wb_ready

module ysyx_25040129_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_read,
    input  logic [1:0]  in_write,
    input  logic [3:0]  in_rd,
    input  logic        in_reg_write,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rsp_err,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        lsu_fault
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        wen_q;
    logic [2:0]  read_q;
    logic [3:0]  rd_q;
    logic        reg_write_q;
    logic [31:0] wb_data_q;
    logic        fault_q;

    logic        is_store;
    logic        is_load;
    logic        misalign;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_shift;
    logic [31:0] load_d;

    // A store wins when both load and store kinds are given.
    assign is_store = (in_write != 2'd0);
    assign is_load  = !is_store && (in_read >= 3'd1) && (in_read <= 3'd5);

    always_comb begin
        misalign = 1'b0;
`ifdef YSYX_25040129_LSU_MISALIGN_CHK_EN
        if (is_store) begin
            case (in_write)
                2'd2:    misalign = in_result[0];
                2'd3:    misalign = |in_result[1:0];
                default: misalign = 1'b0;
            endcase
        end else if (is_load) begin
            case (in_read)
                3'd3, 3'd4: misalign = in_result[0];
                3'd5:       misalign = |in_result[1:0];
                default:    misalign = 1'b0;
            endcase
        end
`endif
    end

    always_comb begin
        wstrb_d = 4'b0000;
        wdata_d = in_wdata;
        case (in_write)
            2'd1: begin
                wstrb_d = 4'b0001 << in_result[1:0];
                wdata_d = {4{in_wdata[7:0]}};
            end
            2'd2: begin
                wstrb_d = 4'b0011 << {in_result[1], 1'b0};
                wdata_d = {2{in_wdata[15:0]}};
            end
            2'd3: begin
                wstrb_d = 4'b1111;
                wdata_d = in_wdata;
            end
            default: begin
                wstrb_d = 4'b0000;
                wdata_d = in_wdata;
            end
        endcase
    end

    assign rdata_shift = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (read_q)
            3'd1:    load_d = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'd2:    load_d = {24'd0, rdata_shift[7:0]};
            3'd3:    load_d = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'd4:    load_d = {16'd0, rdata_shift[15:0]};
            default: load_d = rdata_shift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            wen_q       <= 1'b0;
            read_q      <= 3'd0;
            rd_q        <= 4'd0;
            reg_write_q <= 1'b0;
            wb_data_q   <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        addr_q      <= in_result;
                        wdata_q     <= wdata_d;
                        wstrb_q     <= wstrb_d;
                        wen_q       <= is_store;
                        read_q      <= is_load ? in_read : 3'd0;
                        rd_q        <= in_rd;
                        reg_write_q <= in_reg_write;
                        wb_data_q   <= in_result;
                        fault_q     <= misalign;
                        if ((is_store || is_load) && !misalign)
                            state_q <= S_REQ;
                        else
                            state_q <= S_DONE;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready)
                        state_q <= S_RESP;
                end
                S_RESP: begin
                    if (mem_rsp_valid) begin
                        if (mem_rsp_err) begin
                            fault_q   <= 1'b1;
                            wb_data_q <= addr_q;
                        end else if (!wen_q) begin
                            wb_data_q <= load_d;
                        end else begin
                            wb_data_q <= addr_q;
                        end
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (wb_ready)
                        state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign mem_req_valid = (state_q == S_REQ);
    assign wb_valid      = (state_q == S_DONE);
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = rd_q;
    assign wb_reg_write  = reg_write_q && !fault_q;
    assign lsu_fault     = fault_q;

endmodule
